conv_frame_sequencer: RTL and testbench

CONV_FRAME_SEQUENCER -- requirements
Module: conv_frame_sequencer

---
 rtl/conv_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for a convolution window buffer: clears the buffer, streams a
// width x height pixel frame out of memory in raster order and counts the windows produced.
module conv_frame_sequencer #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [1:0]  PAD_MODE = 2'b01
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [7:0]               cfg_width,
    input  logic [7:0]               cfg_height,
    input  logic [ADDR_W-1:0]        cfg_base_addr,
    input  logic                     stall,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [7:0]        mem_rd_data,
    output logic                     win_clear_n,
    output logic                     win_valid_in,
    output logic signed [7:0]        win_data_in,
    output logic [7:0]               win_img_width,
    output logic [7:0]               win_img_height,
    output logic [1:0]               win_padding_mode,
    input  logic                     win_valid_out,
    output logic                     busy,
    output logic                     done,
    output logic                     err_cfg,
    output logic [15:0]              win_count
);

    localparam int unsigned DIM_W = 8;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    width_q, width_d;
    logic [DIM_W-1:0]    height_q, height_d;
    logic [CNT_W-1:0]    npix_q, npix_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    win_count_q, win_count_d;
    logic                rd_pend_q, rd_pend_d;
    logic                err_cfg_q, err_cfg_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                clear_n_q, clear_n_d;
    logic                issue_c;
    logic                active_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            npix_q      <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            win_count_q <= '0;
            rd_pend_q   <= 1'b0;
            err_cfg_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            clear_n_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            npix_q      <= npix_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            win_count_q <= win_count_d;
            rd_pend_q   <= rd_pend_d;
            err_cfg_q   <= err_cfg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            clear_n_q   <= clear_n_d;
        end
    end

    // Next-state and read issue
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        npix_d      = npix_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        win_count_d = win_count_q;
        err_cfg_d   = err_cfg_q;
        issue_c     = 1'b0;
        active_c    = (state_q == S_CLEAR) || (state_q == S_FETCH) || (state_q == S_DRAIN);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((cfg_width == '0) || (cfg_height == '0)) begin
                        err_cfg_d = 1'b1;
                    end else begin
                        err_cfg_d   = 1'b0;
                        width_d     = cfg_width;
                        height_d    = cfg_height;
                        npix_d      = CNT_W'(cfg_width) * CNT_W'(cfg_height);
                        idx_d       = '0;
                        addr_d      = cfg_base_addr;
                        win_count_d = '0;
                        state_d     = S_CLEAR;
                    end
                end
            end
            S_CLEAR: state_d = S_FETCH;
            S_FETCH: begin
                // abort suppresses the read in its own cycle so nothing new is issued
                if (!stall && !abort) begin
                    issue_c = 1'b1;
                    idx_d   = idx_q + CNT_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    if (idx_q == (npix_q - CNT_W'(1))) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (win_count_q == npix_q) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (active_c && win_valid_out && (win_count_q != '1)) begin
            win_count_d = win_count_q + CNT_W'(1);
        end

        if (active_c && abort) begin
            state_d = S_IDLE;
        end

        rd_pend_d = issue_c;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FINISH);
        clear_n_d = (state_d != S_CLEAR);
    end

    assign mem_rd_en        = issue_c;
    assign mem_addr         = addr_q;
    assign win_valid_in     = rd_pend_q;
    assign win_data_in      = rd_pend_q ? mem_rd_data : '0;
    assign win_clear_n      = clear_n_q;
    assign win_img_width    = width_q;
    assign win_img_height   = height_q;
    assign win_padding_mode = PAD_MODE;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_cfg          = err_cfg_q;
    assign win_count        = win_count_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench: frame tasks queue the expected address stream, a negedge monitor
// pops and compares reads and forwarded pixels; a 1-cycle window buffer model closes the loop.
module tb_conv_frame_sequencer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               stall = 1'b0;
    logic [7:0]         cfg_width = '0;
    logic [7:0]         cfg_height = '0;
    logic [15:0]        cfg_base_addr = '0;
    logic               mem_rd_en;
    logic [15:0]        mem_addr;
    logic signed [7:0]  mem_rd_data = '0;
    logic               win_clear_n;
    logic               win_valid_in;
    logic signed [7:0]  win_data_in;
    logic [7:0]         win_img_width;
    logic [7:0]         win_img_height;
    logic [1:0]         win_padding_mode;
    logic               win_valid_out = 1'b0;
    logic               busy;
    logic               done;
    logic               err_cfg;
    logic [15:0]        win_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int reads_seen = 0;
    int valid_seen = 0;
    int done_cnt = 0;
    int clear_cnt = 0;
    int clear_cyc = -1;
    int first_rd = -1;
    int last_rd = -1;

    logic [15:0]       exp_addr[$];
    logic signed [7:0] exp_data[$];

    conv_frame_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .cfg_width        (cfg_width),
        .cfg_height       (cfg_height),
        .cfg_base_addr    (cfg_base_addr),
        .stall            (stall),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_rd_data      (mem_rd_data),
        .win_clear_n      (win_clear_n),
        .win_valid_in     (win_valid_in),
        .win_data_in      (win_data_in),
        .win_img_width    (win_img_width),
        .win_img_height   (win_img_height),
        .win_padding_mode (win_padding_mode),
        .win_valid_out    (win_valid_out),
        .busy             (busy),
        .done             (done),
        .err_cfg          (err_cfg),
        .win_count        (win_count)
    );

    always #5 clk = ~clk;

    function automatic logic signed [7:0] mem_fn(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'd37 + 16'h1234;
        return 8'(t[15:8] ^ t[7:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pixel memory: data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_fn(mem_addr);
    end

    // Window buffer model: one window per pixel, one cycle later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) win_valid_out <= 1'b0;
        else        win_valid_out <= win_valid_in;
    end

    // Monitor: compares every read and every forwarded pixel against the queues
    always @(negedge clk) begin
        logic [15:0]       a;
        logic signed [7:0] d;
        if (rst_n) begin
            cyc++;
            if (mem_rd_en) begin
                reads_seen++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                check("rd_while_stall", 32'(stall), 32'(0));
                if (exp_addr.size() != 0) begin
                    a = exp_addr.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(a));
                    exp_data.push_back(mem_fn(a));
                end
            end
            if (win_valid_in) begin
                valid_seen++;
                if (exp_data.size() != 0) begin
                    d = exp_data.pop_front();
                    check("win_data_in", 32'(win_data_in), 32'(d));
                end
            end
            if (!win_clear_n) begin
                clear_cnt++;
                clear_cyc = cyc;
            end
            if (done) done_cnt++;
        end
    end

    task automatic check_reset_outputs();
        check("rst_busy",      32'(busy), 32'(0));
        check("rst_done",      32'(done), 32'(0));
        check("rst_err_cfg",   32'(err_cfg), 32'(0));
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'(0));
        check("rst_mem_addr",  32'(mem_addr), 32'(0));
        check("rst_valid_in",  32'(win_valid_in), 32'(0));
        check("rst_data_in",   32'(win_data_in), 32'(0));
        check("rst_win_count", 32'(win_count), 32'(0));
        check("rst_img_w",     32'(win_img_width), 32'(0));
        check("rst_img_h",     32'(win_img_height), 32'(0));
        check("rst_clear_n",   32'(win_clear_n), 32'(1));
        check("rst_pad_mode",  32'(win_padding_mode), 32'(1));
    endtask

    // mode: 0 no stall, 1 random stall (param %), 2 two stall cycles after param reads,
    //       3 abort after param reads, 4 repeated start after param reads, 5 reset after param reads
    task automatic run_frame(input int w, input int h, input logic [15:0] base,
                             input int mode, input int param);
        int n;
        int budget;
        int stall_cnt;
        bit fin;
        bit fired;
        n = w * h;
        budget = 4 * n + 100;
        stall_cnt = 0;
        fin = 1'b0;
        fired = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < n; i++) exp_addr.push_back(16'(int'(base) + i));
        reads_seen = 0; valid_seen = 0; done_cnt = 0; clear_cnt = 0;
        first_rd = -1; last_rd = -1; clear_cyc = -1;

        @(posedge clk); #1;
        cfg_width = 8'(w); cfg_height = 8'(h); cfg_base_addr = base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(1));
        check("clear_low",        32'(win_clear_n), 32'(0));
        check("err_cfg_cleared",  32'(err_cfg), 32'(0));
        check("count_cleared",    32'(win_count), 32'(0));

        while (!fin && budget > 0) begin
            budget--;
            @(posedge clk); #1;
            stall = 1'b0; abort = 1'b0; start = 1'b0;
            case (mode)
                1: stall = ($urandom_range(0, 99) < param);
                2: if (reads_seen >= param && stall_cnt < 2) begin
                       stall = 1'b1;
                       if (stall_cnt == 0) check("fwd_during_stall", 32'(win_valid_in), 32'(1));
                       stall_cnt++;
                   end
                3: if (reads_seen == param && !fired) begin abort = 1'b1; fired = 1'b1; end
                4: if (reads_seen == param && !fired) begin
                       start = 1'b1; cfg_width = 8'd2; cfg_height = 8'd2; cfg_base_addr = 16'h0;
                       fired = 1'b1;
                   end
                5: if (reads_seen == param && !fired) begin rst_n = 1'b0; fired = 1'b1; end
                default: ;
            endcase
            if (done_cnt > 0 || (fired && (mode == 3 || mode == 5))) fin = 1'b1;
        end

        if (mode == 3) begin
            @(negedge clk);
            check("rd_en_at_abort", 32'(mem_rd_en), 32'(0));
            @(posedge clk); #1;
            abort = 1'b0;
            check("busy_after_abort", 32'(busy), 32'(0));
            repeat (5) @(posedge clk);
            #1;
            check("abort_reads",     32'(reads_seen), 32'(param));
            check("abort_forwarded", 32'(valid_seen), 32'(param));
            check("abort_no_done",   32'(done_cnt), 32'(0));
            check("abort_idle",      32'(busy), 32'(0));
        end else if (mode == 5) begin
            #1;
            check_reset_outputs();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            check("reset_no_done", 32'(done_cnt), 32'(0));
            check("reset_idle",    32'(busy), 32'(0));
            check("reset_count",   32'(win_count), 32'(0));
        end else begin
            repeat (3) @(posedge clk);
            #1;
            check("done_pulses",   32'(done_cnt), 32'(1));
            check("reads",         32'(reads_seen), 32'(n));
            check("forwarded",     32'(valid_seen), 32'(n));
            check("addr_left",     32'(exp_addr.size()), 32'(0));
            check("win_count",     32'(win_count), 32'(n));
            check("idle_at_end",   32'(busy), 32'(0));
            check("clear_cycles",  32'(clear_cnt), 32'(1));
            check("img_width",     32'(win_img_width), 32'(w));
            check("img_height",    32'(win_img_height), 32'(h));
            check("pad_mode",      32'(win_padding_mode), 32'(1));
            if (mode == 0) begin
                check("first_rd_after_clear", 32'(first_rd), 32'(clear_cyc + 1));
                check("reads_back_to_back",   32'(last_rd - first_rd), 32'(n - 1));
            end
        end
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_frame(4, 4, 16'h0100, 0, 0);
        run_frame(3, 3, 16'h0200, 2, 4);

        // zero-sized frames are rejected and stay idle
        reads_seen = 0;
        @(posedge clk); #1;
        cfg_width = 8'd0; cfg_height = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_w0_set",  32'(err_cfg), 32'(1));
        check("err_w0_busy", 32'(busy), 32'(0));
        repeat (4) @(posedge clk);
        #1;
        check("err_w0_reads", 32'(reads_seen), 32'(0));
        check("err_w0_idle",  32'(busy), 32'(0));
        cfg_width = 8'd5; cfg_height = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_h0_set",  32'(err_cfg), 32'(1));
        check("err_h0_busy", 32'(busy), 32'(0));
        run_frame(2, 2, 16'h0300, 0, 0);

        run_frame(8, 8, 16'h0400, 3, 10);
        run_frame(8, 8, 16'h0400, 0, 0);
        run_frame(6, 5, 16'h0500, 4, 7);
        run_frame(6, 5, 16'h0600, 5, 9);
        run_frame(3, 4, 16'h0700, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_frame(int'($urandom_range(1, 10)), int'($urandom_range(1, 10)),
                      16'($urandom), 1, 30);
        end
        run_frame(255, 255, 16'hFFF0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
